// File: rtl/cnt_seq_pkg.sv
// Shared types and helpers for the counter sequencer: state encoding, default
// widths and the modulo-N preset calculation.
package cnt_seq_pkg;

  localparam int unsigned CntWDefault = 4;
  localparam int unsigned RepWDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } seq_state_e;

  // Preset that makes a w-bit up-counter wrap after n cycles; n == 0 yields
  // a full 2^w period.
  function automatic logic [31:0] calc_preset(input logic [31:0] n, input int unsigned w);
    logic [31:0] modulus;
    modulus = 32'd1 << w;
    return (modulus - n) & (modulus - 32'd1);
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Sequencer that turns a loadable up-counter into a programmable modulo-N timer.
// Optional pause input is enabled by defining CNT_SEQ_CTRL_PAUSE_EN.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int unsigned CW = CntWDefault,
  parameter int unsigned RW = RepWDefault
) (
  input  logic          clk,
  input  logic          mr,
  input  logic          start,
  input  logic          stop,
`ifdef CNT_SEQ_CTRL_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [CW-1:0] mod_n,
  input  logic [RW-1:0] rep_n,
  output logic          cnt_load_n,
  output logic          cnt_en,
  output logic [CW-1:0] cnt_d,
  input  logic [CW-1:0] cnt_q,
  input  logic          cnt_co,
  output logic          busy,
  output logic          tick,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] preset_q, preset_d;
  logic [RW-1:0] remain_q, remain_d;
  logic          paused;

`ifdef CNT_SEQ_CTRL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign cnt_d = preset_q;

  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    remain_d   = remain_q;
    cnt_load_n = 1'b1;
    cnt_en     = 1'b0;
    busy       = 1'b0;
    tick       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          preset_d = CW'(calc_preset(32'(mod_n), CW));
          remain_d = rep_n;
          state_d  = StLoad;
        end
      end

      StLoad: begin
        busy       = 1'b1;
        cnt_load_n = 1'b0;
        state_d    = stop ? StIdle : StRun;
      end

      StRun: begin
        busy = 1'b1;
        // Reload on the wrap edge so the period is exactly N cycles.
        if (!paused) begin
          cnt_en     = 1'b1;
          cnt_load_n = ~cnt_co;
          tick       = cnt_co;
        end
        if (stop) begin
          state_d = StIdle;
        end else if (tick) begin
          // remain_q == 0 means free-running until stop.
          if (remain_q != '0) begin
            remain_d = remain_q - RW'(1);
          end
          if (remain_q == RW'(1)) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q  <= StIdle;
      preset_q <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      remain_q <= remain_d;
    end
  end

  // Carry-out from the partner counter must agree with its read-back state.
  co_consistent: assert property (@(posedge clk) disable iff (mr)
    (state_q == StRun && cnt_en) |-> (cnt_co == (cnt_q == '1)));

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl driving a behavioural 74161-style counter.
// Covers the pause feature when CNT_SEQ_CTRL_PAUSE_EN is defined.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       mr;
  logic       start;
  logic       stop;
  logic [3:0] mod_n;
  logic [3:0] rep_n;
  logic       cnt_load_n;
  logic       cnt_en;
  logic [3:0] cnt_d;
  logic [3:0] cnt_q = 4'd0;
  logic       cnt_co;
  logic       busy;
  logic       tick;
  logic       done;
`ifdef CNT_SEQ_CTRL_PAUSE_EN
  logic       pause;
`endif

  typedef struct {
    bit is_done;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnt_seq_ctrl dut (
    .clk       (clk),
    .mr        (mr),
    .start     (start),
    .stop      (stop),
`ifdef CNT_SEQ_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .mod_n     (mod_n),
    .rep_n     (rep_n),
    .cnt_load_n(cnt_load_n),
    .cnt_en    (cnt_en),
    .cnt_d     (cnt_d),
    .cnt_q     (cnt_q),
    .cnt_co    (cnt_co),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  // cnt4_model: synchronous active-low load has priority over count enable.
  always @(posedge clk) begin
    if (!cnt_load_n) cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end
  assign cnt_co = (cnt_q == 4'hF) && cnt_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every tick/done the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mr === 1'b0 && (tick === 1'b1 || done === 1'b1)) begin
      ev_t e;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: got tick=%0b done=%0b at cycle %0d, required none",
                 tick, done, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_kind_is_done", {31'b0, done}, {31'b0, e.is_done});
        chk("event_cycle", cyc, e.cyc);
        if (done) chk("busy_low_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Reference: start in cycle c0 -> tick k in cycle c0+1+N*k, done one cycle after tick R.
  // A stop in cycle s keeps ticks up to and including s and cancels done if s <= last tick.
  task automatic run_seq(input int n, input int r, input int stop_off, input bit mid_start);
    int  neff, c0, stop_cyc, end_cyc, tc, done_cyc;
    bit  stopped, completes;
    neff = (n == 0) ? 16 : n;
    step();
    c0       = cyc;
    stopped  = (stop_off >= 0);
    stop_cyc = c0 + stop_off;
    mod_n    = 4'(n);
    rep_n    = 4'(r);
    start    = 1'b1;
    stop     = 1'b0;
    for (int k = 1; (r == 0) || (k <= r); k++) begin
      tc = c0 + 1 + neff * k;
      if (stopped && tc > stop_cyc) break;
      sb.push_back('{1'b0, tc});
    end
    done_cyc  = c0 + 2 + neff * r;
    completes = (r != 0) && (!stopped || stop_cyc > done_cyc - 1);
    if (completes) begin
      sb.push_back('{1'b1, done_cyc});
      end_cyc = done_cyc + 1;
    end else begin
      end_cyc = stop_cyc + 1;
    end
    step();
    mod_n = 4'($urandom_range(0, 15));
    while (cyc < end_cyc) begin
      stop  = stopped && (cyc == stop_cyc);
      start = mid_start && (cyc == c0 + 3);
      if (start) mod_n = 4'($urandom_range(0, 15));
      if (cyc == c0 + 1) begin
        @(negedge clk);
        chk("preset_cnt_d", {28'b0, cnt_d}, {28'b0, 4'((16 - n) % 16)});
        chk("load_strobe", {31'b0, cnt_load_n}, 32'd0);
        chk("busy_in_load", {31'b0, busy}, 32'd1);
      end
      step();
    end
    stop  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy_after_run", {31'b0, busy}, 32'd0);
    chk("idle_en_after_run", {31'b0, cnt_en}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r, so, neff;
    bit ms;
    mr    = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mod_n = 4'd0;
    rep_n = 4'd0;
`ifdef CNT_SEQ_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    @(negedge clk);
    chk("rst_load_n", {31'b0, cnt_load_n}, 32'd1);
    chk("rst_en", {31'b0, cnt_en}, 32'd0);
    chk("rst_cnt_d", {28'b0, cnt_d}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_tick", {31'b0, tick}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    start = 1'b1;
    mod_n = 4'd5;
    rep_n = 4'd3;
    step();
    step();
    start = 1'b0;
    mr    = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("start_in_reset_ignored_busy", {31'b0, busy}, 32'd0);
    chk("start_in_reset_ignored_load", {31'b0, cnt_load_n}, 32'd1);

    run_seq(5, 3, -1, 1'b0);
    run_seq(0, 1, -1, 1'b0);
    run_seq(1, 4, -1, 1'b0);
    run_seq(3, 0, 23, 1'b0);   // stop the cycle after the 7th tick
    run_seq(5, 3, 16, 1'b0);   // stop coincides with the final tick
    run_seq(6, 2, -1, 1'b1);   // start while busy must not alter the period
    run_seq(7, 2, 1, 1'b0);    // stop during load

    // Mid-run reset forces outputs to reset values without waiting for a clock.
    step();
    mod_n = 4'd0;
    rep_n = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 mr = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
    chk("midrun_rst_en", {31'b0, cnt_en}, 32'd0);
    chk("midrun_rst_load_n", {31'b0, cnt_load_n}, 32'd1);
    chk("midrun_rst_cnt_d", {28'b0, cnt_d}, 32'd0);
    step();
    mr = 1'b0;
    step();
    @(negedge clk);
    chk("after_midrun_rst_busy", {31'b0, busy}, 32'd0);

`ifdef CNT_SEQ_CTRL_PAUSE_EN
    begin
      int c0;
      step();
      c0    = cyc;
      mod_n = 4'd4;
      rep_n = 4'd1;
      start = 1'b1;
      sb.push_back('{1'b0, c0 + 11});
      sb.push_back('{1'b1, c0 + 12});
      step();
      start = 1'b0;
      step();
      step();
      step();
      pause = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("paused_cnt_q", {28'b0, cnt_q}, 32'd14);
        chk("paused_en", {31'b0, cnt_en}, 32'd0);
        step();
      end
      pause = 1'b0;
      while (cyc < c0 + 13) step();
      @(negedge clk);
      chk("pause_run_idle", {31'b0, busy}, 32'd0);
    end
`endif

    for (int i = 0; i < 24; i++) begin
      n    = int'($urandom_range(0, 15));
      r    = int'($urandom_range(0, 5));
      neff = (n == 0) ? 16 : n;
      if (r == 0 || $urandom_range(0, 1) == 1)
        so = int'($urandom_range(1, (r == 0) ? 2 + neff * 6 : 2 + neff * r));
      else
        so = -1;
      ms = (so < 0 || so >= 3) && ($urandom_range(0, 1) == 1);
      run_seq(n, r, so, ms);
    end

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
